interrupt_controller: RTL and testbench
=======================================

Name: interrupt_controller

Overview:
Interrupt and vector sequencer that sits directly upstream of the cpu core. It receives asynchronous IRQ sources and the NMI pin, and synchronises, masks, prioritises and latches them. When the control unit acknowledges a request, it supplies the two-byte vector address sequence: RESET FFFC/FFFD, NMI FFFA/FFFB, IRQ FFFE/FFFF.

Parameters:
NUM_IRQ, 4, number of maskable interrupt sources (1..8)
SYNC_STAGES, 2, flip-flop stages per asynchronous input synchroniser (>=2)

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst  input  1  asynchronous, active-low reset
irq_src  input  NUM_IRQ  asynchronous interrupt sources, active-high
nmi_n  input  1  asynchronous NMI pin, active-low, falling-edge sensitive
i_flag  input  1  CPU interrupt-disable flag; 1 blocks IRQ
int_ack  input  1  one-cycle pulse from the control unit that starts vector fetch
cfg_we  input  1  write strobe for the enable register
cfg_wdata  input  NUM_IRQ  enable-register write data
irq_enable  output  NUM_IRQ  current per-source enable register
irq_pending  output  NUM_IRQ  synchronised, enabled source status
int_req  output  1  an interrupt or reset request is pending; the CPU should take it
int_type  output  2  00 none, 01 IRQ, 10 NMI, 11 RESET (type being requested or serviced)
vector_addr  output  16  vector byte address; valid when vector_valid=1
vector_valid  output  1  vector_addr is valid this cycle
busy  output  1  ACK_LO or ACK_HI state active

Behaviour:
- Reset (rst=0, async): state=IDLE, irq_enable=all 1, sync chains=0 (nmi chain=1), nmi_pending=0, reset_pending=1, vector_valid=0, vector_addr=0000, int_type=11, int_req=1 once rst releases.
- Synchronisers: each irq_src bit and nmi_n pass through SYNC_STAGES flops. Input-to-visible latency is SYNC_STAGES cycles.
- NMI: a falling edge on synchronised nmi_n (previous 1, current 0) sets nmi_pending. A held-low NMI produces only one edge. nmi_pending is cleared on entry to ACK_LO when the NMI is selected.
- An NMI edge that arrives during ACK_LO or ACK_HI sets nmi_pending again and is serviced afterwards. It is never lost.
- IRQ: irq_pending = sync(irq_src) & irq_enable. irq_req = |irq_pending & ~i_flag. IRQ is level-sensitive; nothing is latched.
- Priority: reset_pending > nmi_pending > irq_req. int_req = any of the three, and is forced to 0 while busy. int_type reflects the highest-priority pending request in IDLE, and is held constant through ACK_LO/ACK_HI.
- Enable register: cfg_we=1 loads cfg_wdata at the clock edge. The new value affects irq_pending the following cycle.
- FSM:
  IDLE: if int_ack=1 and int_req=1 -> ACK_LO. Latch the selected type and clear its pending bit (reset_pending or nmi_pending). int_ack with int_req=0 is ignored.
  ACK_LO: vector_valid=1, vector_addr = base (FFFC/FFFA/FFFE) -> ACK_HI.
  ACK_HI: vector_valid=1, vector_addr = base+1 -> IDLE.
- Latency: int_ack at cycle N gives the low vector at N+1 and the high vector at N+2. vector_valid=0 at N+3 unless a new ack arrives.
- int_ack during ACK_LO or ACK_HI is ignored.
- IRQ deassertion after ack does not abort the sequence. An IRQ-type vector is still emitted.
- vector_addr holds its last value when vector_valid=0.
- Asynchronous reset mid-sequence returns to IDLE immediately, with reset_pending=1.

Optional Feature:
IRQ_LATCH_EN
- Defined: each source has a sticky pending bit, set on a rising edge of the synchronised irq_src while enabled. irq_pending shows the sticky bits. cfg_we with cfg_wdata bits written to an enable bit of 0 is unchanged; a separate rule applies: a write also clears (write-1-to-clear) the pending bits where cfg_wdata=1 AND the enable bit becomes 1. A simultaneous set and clear leaves the bit set.
- Undefined: purely level-sensitive behaviour as above, with no sticky state.

Test Plan:
- Release rst, wait 1 cycle: int_req=1, int_type=11. Pulse int_ack -> vector FFFC then FFFD. Then int_req=0, int_type=00.
- irq_src=0001, i_flag=0, wait SYNC_STAGES: int_req=1, type 01. Ack -> FFFE, FFFF. With i_flag=1: int_req stays 0.
- Drive nmi_n 1->0 while irq_src=0001 active: type 10 wins. Ack -> FFFA, FFFB. Then IRQ remains requested with type 01. Holding nmi_n low gives no second NMI.
- A second nmi_n falling edge during ACK_HI: after the sequence, int_req=1 and type 10 again.
- cfg_we=1, cfg_wdata=1110 with irq_src=0001: irq_pending=0000, int_req=0. Writing 1111 restores int_req=1 one cycle later.
- Assert rst during ACK_LO: vector_valid=0 immediately, and after release the RESET sequence is requested.

Source files
------------

// File: rtl/interrupt_controller.sv
// Interrupt and vector sequencer: synchronises, masks, prioritises and latches RESET/NMI/IRQ
// requests, then emits the two-byte vector address on acknowledge. Optional macro: IRQ_LATCH_EN.
module interrupt_controller #(
  parameter int NUM_IRQ     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic               nmi_n,
  input  logic               i_flag,
  input  logic               int_ack,
  input  logic               cfg_we,
  input  logic [NUM_IRQ-1:0] cfg_wdata,
  output logic [NUM_IRQ-1:0] irq_enable,
  output logic [NUM_IRQ-1:0] irq_pending,
  output logic               int_req,
  output logic [1:0]         int_type,
  output logic [15:0]        vector_addr,
  output logic               vector_valid,
  output logic               busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACK_LO = 2'b01,
    ST_ACK_HI = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    T_NONE  = 2'b00,
    T_IRQ   = 2'b01,
    T_NMI   = 2'b10,
    T_RESET = 2'b11
  } int_type_t;

  state_t             state, state_next;
  int_type_t          sel_type, type_q;
  logic [NUM_IRQ-1:0] irq_sync [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] nmi_sync;
  logic [NUM_IRQ-1:0] irq_s;
  logic               nmi_s, nmi_prev, nmi_edge;
  logic               nmi_pending, reset_pending;
  logic               irq_req, take;

  // NOTE: the synchroniser array is ordinary flops, not a RAM, so every entry gets an async reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) irq_sync[i] <= '0;
      nmi_sync <= '1;
    end else begin
      irq_sync[0] <= irq_src;
      for (int i = 1; i < SYNC_STAGES; i++) irq_sync[i] <= irq_sync[i-1];
      nmi_sync <= {nmi_sync[SYNC_STAGES-2:0], nmi_n};
    end
  end

  assign irq_s    = irq_sync[SYNC_STAGES-1];
  assign nmi_s    = nmi_sync[SYNC_STAGES-1];
  assign nmi_edge = nmi_prev & ~nmi_s;

  // NOTE: all state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_enable <= '1;
      nmi_prev   <= 1'b1;
    end else begin
      if (cfg_we) irq_enable <= cfg_wdata;
      nmi_prev <= nmi_s;
    end
  end

`ifdef IRQ_LATCH_EN
  logic [NUM_IRQ-1:0] irq_s_prev, irq_sticky, irq_rise, irq_clr;

  assign irq_rise = irq_s & ~irq_s_prev & irq_enable;
  // Write-1-to-clear targets bits whose enable becomes 1, i.e. the written ones; a same-cycle rise wins.
  assign irq_clr  = {NUM_IRQ{cfg_we}} & cfg_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_s_prev <= '0;
      irq_sticky <= '0;
    end else begin
      irq_s_prev <= irq_s;
      irq_sticky <= (irq_sticky & ~irq_clr) | irq_rise;
    end
  end

  assign irq_pending = irq_sticky;
`else
  assign irq_pending = irq_s & irq_enable;
`endif

  assign irq_req = (|irq_pending) & ~i_flag;
  assign busy    = (state != ST_IDLE);

  always_comb begin
    if (reset_pending)    sel_type = T_RESET;
    else if (nmi_pending) sel_type = T_NMI;
    else if (irq_req)     sel_type = T_IRQ;
    else                  sel_type = T_NONE;
  end

  assign int_req      = (reset_pending | nmi_pending | irq_req) & ~busy;
  assign int_type     = busy ? type_q : sel_type;
  assign vector_valid = busy;
  assign take         = (state == ST_IDLE) & int_ack & int_req;

  function automatic logic [15:0] vec_base(input int_type_t t);
    case (t)
      T_RESET: vec_base = 16'hFFFC;
      T_NMI:   vec_base = 16'hFFFA;
      default: vec_base = 16'hFFFE;
    endcase
  endfunction

  // NOTE: defaulting state_next before the case keeps this block free of inferred latches.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (take) state_next = ST_ACK_LO;
      ST_ACK_LO: state_next = ST_ACK_HI;
      ST_ACK_HI: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      type_q        <= T_RESET;
      reset_pending <= 1'b1;
      nmi_pending   <= 1'b0;
      vector_addr   <= 16'h0000;
    end else begin
      state <= state_next;
      if (take) begin
        type_q      <= sel_type;
        vector_addr <= vec_base(sel_type);
      end else if (state == ST_ACK_LO) begin
        vector_addr <= {vector_addr[15:1], 1'b1};
      end
      if (take && sel_type == T_RESET) reset_pending <= 1'b0;
      // An edge coinciding with the NMI being taken re-arms it, so no edge is ever dropped.
      nmi_pending <= (nmi_pending & ~(take && sel_type == T_NMI)) | nmi_edge;
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Table-driven bench for interrupt_controller: each record is driven for one clock and its
// expected outputs are queued, then popped and compared on the following falling edge.
module tb_interrupt_controller;

  localparam int NUM_IRQ     = 4;
  localparam int SYNC_STAGES = 2;

  typedef struct {
    string       name;
    logic [3:0]  irq;
    logic        nmi;
    logic        ifl;
    logic        ack;
    logic        we;
    logic [3:0]  wd;
    logic        req;
    logic [1:0]  typ;
    logic        vv;
    logic [15:0] addr;
    logic        bsy;
    logic [3:0]  pend;
    logic [3:0]  en;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM_IRQ-1:0] irq_src;
  logic               nmi_n, i_flag, int_ack, cfg_we;
  logic [NUM_IRQ-1:0] cfg_wdata;
  logic [NUM_IRQ-1:0] irq_enable, irq_pending;
  logic               int_req, vector_valid, busy;
  logic [1:0]         int_type;
  logic [15:0]        vector_addr;

  int   errors = 0;
  int   checks = 0;
  vec_t sb[$];
  vec_t tbl[$];
  vec_t post[$];

  interrupt_controller #(.NUM_IRQ(NUM_IRQ), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst(rst), .irq_src(irq_src), .nmi_n(nmi_n), .i_flag(i_flag),
    .int_ack(int_ack), .cfg_we(cfg_we), .cfg_wdata(cfg_wdata),
    .irq_enable(irq_enable), .irq_pending(irq_pending), .int_req(int_req),
    .int_type(int_type), .vector_addr(vector_addr), .vector_valid(vector_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(string n, logic [3:0] irq, logic nmi, logic ifl, logic ack,
                              logic we, logic [3:0] wd, logic req, logic [1:0] typ, logic vv,
                              logic [15:0] addr, logic bsy, logic [3:0] pend, logic [3:0] en);
    vec_t v;
    v.name = n; v.irq = irq; v.nmi = nmi; v.ifl = ifl; v.ack = ack; v.we = we; v.wd = wd;
    v.req = req; v.typ = typ; v.vv = vv; v.addr = addr; v.bsy = bsy; v.pend = pend; v.en = en;
    return v;
  endfunction

  task automatic step(input vec_t v);
    vec_t e;
    irq_src = v.irq; nmi_n = v.nmi; i_flag = v.ifl; int_ack = v.ack;
    cfg_we = v.we; cfg_wdata = v.wd;
    sb.push_back(v);
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", v.name);
    end else begin
      e = sb.pop_front();
      check({e.name, "/int_req"},      {15'd0, int_req},      {15'd0, e.req});
      check({e.name, "/int_type"},     {14'd0, int_type},     {14'd0, e.typ});
      check({e.name, "/vector_valid"}, {15'd0, vector_valid}, {15'd0, e.vv});
      check({e.name, "/vector_addr"},  vector_addr,           e.addr);
      check({e.name, "/busy"},         {15'd0, busy},         {15'd0, e.bsy});
      check({e.name, "/irq_pending"},  {12'd0, irq_pending},  {12'd0, e.pend});
      check({e.name, "/irq_enable"},   {12'd0, irq_enable},   {12'd0, e.en});
    end
  endtask

  initial begin
    //                 name           irq  nmi ifl ack we  wd    req typ vv addr      bsy pend  en
    tbl.push_back(mk("rst_req",     4'h0, 1, 0, 0, 0, 4'h0,  1, 3, 0, 16'h0000, 0, 4'h0, 4'hF));
    tbl.push_back(mk("rst_lo",      4'h0, 1, 0, 1, 0, 4'h0,  0, 3, 1, 16'hFFFC, 1, 4'h0, 4'hF));
    tbl.push_back(mk("rst_hi",      4'h0, 1, 0, 0, 0, 4'h0,  0, 3, 1, 16'hFFFD, 1, 4'h0, 4'hF));
    tbl.push_back(mk("rst_done",    4'h0, 1, 0, 0, 0, 4'h0,  0, 0, 0, 16'hFFFD, 0, 4'h0, 4'hF));
    tbl.push_back(mk("ack_ignored", 4'h0, 1, 0, 1, 0, 4'h0,  0, 0, 0, 16'hFFFD, 0, 4'h0, 4'hF));
    tbl.push_back(mk("irq_sync1",   4'h1, 1, 0, 0, 0, 4'h0,  0, 0, 0, 16'hFFFD, 0, 4'h0, 4'hF));
    tbl.push_back(mk("irq_sync2",   4'h1, 1, 0, 0, 0, 4'h0,  1, 1, 0, 16'hFFFD, 0, 4'h1, 4'hF));
    tbl.push_back(mk("irq_lo",      4'h1, 1, 0, 1, 0, 4'h0,  0, 1, 1, 16'hFFFE, 1, 4'h1, 4'hF));
    tbl.push_back(mk("irq_hi_drop", 4'h0, 1, 0, 0, 0, 4'h0,  0, 1, 1, 16'hFFFF, 1, 4'h1, 4'hF));
    tbl.push_back(mk("irq_done",    4'h0, 1, 0, 0, 0, 4'h0,  0, 0, 0, 16'hFFFF, 0, 4'h0, 4'hF));
    tbl.push_back(mk("iflag_s1",    4'h1, 1, 1, 0, 0, 4'h0,  0, 0, 0, 16'hFFFF, 0, 4'h0, 4'hF));
    tbl.push_back(mk("iflag_block", 4'h1, 1, 1, 0, 0, 4'h0,  0, 0, 0, 16'hFFFF, 0, 4'h1, 4'hF));
    tbl.push_back(mk("iflag_off",   4'h1, 1, 0, 0, 0, 4'h0,  1, 1, 0, 16'hFFFF, 0, 4'h1, 4'hF));
    tbl.push_back(mk("nmi_s1",      4'h1, 0, 0, 0, 0, 4'h0,  1, 1, 0, 16'hFFFF, 0, 4'h1, 4'hF));
    tbl.push_back(mk("nmi_s2",      4'h1, 0, 0, 0, 0, 4'h0,  1, 1, 0, 16'hFFFF, 0, 4'h1, 4'hF));
    tbl.push_back(mk("nmi_wins",    4'h1, 0, 0, 0, 0, 4'h0,  1, 2, 0, 16'hFFFF, 0, 4'h1, 4'hF));
    tbl.push_back(mk("nmi_lo",      4'h1, 0, 0, 1, 0, 4'h0,  0, 2, 1, 16'hFFFA, 1, 4'h1, 4'hF));
    tbl.push_back(mk("nmi_hi",      4'h1, 0, 0, 0, 0, 4'h0,  0, 2, 1, 16'hFFFB, 1, 4'h1, 4'hF));
    tbl.push_back(mk("nmi_then_irq",4'h1, 0, 0, 0, 0, 4'h0,  1, 1, 0, 16'hFFFB, 0, 4'h1, 4'hF));
    tbl.push_back(mk("nmi_held1",   4'h1, 0, 0, 0, 0, 4'h0,  1, 1, 0, 16'hFFFB, 0, 4'h1, 4'hF));
    tbl.push_back(mk("nmi_held2",   4'h1, 0, 0, 0, 0, 4'h0,  1, 1, 0, 16'hFFFB, 0, 4'h1, 4'hF));
    tbl.push_back(mk("nmi_rise1",   4'h1, 1, 0, 0, 0, 4'h0,  1, 1, 0, 16'hFFFB, 0, 4'h1, 4'hF));
    tbl.push_back(mk("nmi_rise2",   4'h1, 1, 0, 0, 0, 4'h0,  1, 1, 0, 16'hFFFB, 0, 4'h1, 4'hF));
    tbl.push_back(mk("nmi2_irq_lo", 4'h1, 0, 0, 1, 0, 4'h0,  0, 1, 1, 16'hFFFE, 1, 4'h1, 4'hF));
    tbl.push_back(mk("nmi2_irq_hi", 4'h1, 0, 0, 0, 0, 4'h0,  0, 1, 1, 16'hFFFF, 1, 4'h1, 4'hF));
    tbl.push_back(mk("nmi2_kept",   4'h1, 0, 0, 0, 0, 4'h0,  1, 2, 0, 16'hFFFF, 0, 4'h1, 4'hF));
    tbl.push_back(mk("nmi2_lo",     4'h1, 0, 0, 1, 0, 4'h0,  0, 2, 1, 16'hFFFA, 1, 4'h1, 4'hF));
    tbl.push_back(mk("nmi2_hi",     4'h1, 0, 0, 0, 0, 4'h0,  0, 2, 1, 16'hFFFB, 1, 4'h1, 4'hF));
    tbl.push_back(mk("nmi2_done",   4'h1, 1, 0, 0, 0, 4'h0,  1, 1, 0, 16'hFFFB, 0, 4'h1, 4'hF));
    tbl.push_back(mk("en_mask",     4'h1, 1, 0, 0, 1, 4'hE,  0, 0, 0, 16'hFFFB, 0, 4'h0, 4'hE));
    tbl.push_back(mk("en_hold",     4'h1, 1, 0, 0, 0, 4'h0,  0, 0, 0, 16'hFFFB, 0, 4'h0, 4'hE));
    tbl.push_back(mk("en_restore",  4'h1, 1, 0, 0, 1, 4'hF,  1, 1, 0, 16'hFFFB, 0, 4'h1, 4'hF));
    tbl.push_back(mk("mid_lo",      4'h1, 1, 0, 1, 0, 4'h0,  0, 1, 1, 16'hFFFE, 1, 4'h1, 4'hF));

    post.push_back(mk("prst_req",   4'h1, 1, 0, 0, 0, 4'h0,  1, 3, 0, 16'h0000, 0, 4'h0, 4'hF));
    post.push_back(mk("prst_lo",    4'h1, 1, 0, 1, 0, 4'h0,  0, 3, 1, 16'hFFFC, 1, 4'h1, 4'hF));
    post.push_back(mk("prst_hi",    4'h1, 1, 0, 0, 0, 4'h0,  0, 3, 1, 16'hFFFD, 1, 4'h1, 4'hF));
    post.push_back(mk("prst_irq",   4'h1, 1, 0, 0, 0, 4'h0,  1, 1, 0, 16'hFFFD, 0, 4'h1, 4'hF));

    rst = 1'b0; irq_src = '0; nmi_n = 1'b1; i_flag = 1'b0; int_ack = 1'b0;
    cfg_we = 1'b0; cfg_wdata = '0;
    repeat (3) @(negedge clk);
    check("reset/vector_valid", {15'd0, vector_valid}, 16'd0);
    check("reset/vector_addr",  vector_addr, 16'h0000);
    check("reset/int_type",     {14'd0, int_type}, 16'd3);
    check("reset/busy",         {15'd0, busy}, 16'd0);
    check("reset/irq_enable",   {12'd0, irq_enable}, 16'h000F);
    rst = 1'b1;

    foreach (tbl[i]) step(tbl[i]);

    // Asynchronous reset while the IRQ vector sequence sits in ACK_LO.
    int_ack = 1'b0;
    rst = 1'b0;
    #1;
    check("midrst/vector_valid", {15'd0, vector_valid}, 16'd0);
    check("midrst/busy",         {15'd0, busy}, 16'd0);
    check("midrst/int_type",     {14'd0, int_type}, 16'd3);
    check("midrst/vector_addr",  vector_addr, 16'h0000);
    @(negedge clk);
    rst = 1'b1;

    foreach (post[i]) step(post[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
